// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus shared by the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one instruction at a time, exposes its decoded
// fields, and computes the next PC when the execute stage resolves it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  imem,
  output logic [5:0]          opcode,
  output logic [5:0]          function_val,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [15:0]         imm16,
  output logic [25:0]         target26,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  input  logic                resolve,
  input  logic [1:0]          counter_selector,
  input  logic [2:0]          branch_type,
  input  logic                flag_zero,
  input  logic                flag_sign,
  input  logic                flag_carry,
  input  logic                flag_overflow,
  input  logic [31:0]         reg_target
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]        state;
  logic [31:0]       instr;
  logic              cond;
  logic [ADDR_W-1:0] next_pc;

  // Field outputs are slices of the latched word, so resetting it clears them all
  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign shamt        = instr[10:6];
  assign function_val = instr[5:0];
  assign imm16        = instr[15:0];
  assign target26     = instr[25:0];

  assign pc_plus4       = pc + ADDR_W'(4);
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;

  // Branch condition selected by branch_type from the execute-stage flags
  always_comb begin
    cond = 1'b1;
    case (branch_type)
      3'b000:  cond = 1'b1;
      3'b001:  cond = flag_zero;
      3'b010:  cond = !flag_zero;
      3'b011:  cond = flag_carry;
      3'b100:  cond = !flag_carry;
      3'b101:  cond = flag_sign;
      3'b110:  cond = !flag_sign;
      default: cond = flag_overflow;
    endcase
  end

  // Next-PC source selected by counter_selector; all adds wrap modulo 2^32
  always_comb begin
    next_pc = pc_plus4;
    case (counter_selector)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = cond ? pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00} : pc_plus4;
      2'b10:   next_pc = {pc_plus4[31:28], target26, 2'b00};
      default: next_pc = reg_target & ~32'h0000_0003;
    endcase
  end

  // Fetch/issue state machine; pc moves only on a resolve in ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (resolve) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner-case
// sequences and randomized resolves checked against a behavioural next-PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, function_val;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        resolve;
  logic [1:0]  counter_selector;
  logic [2:0]  branch_type;
  logic        flag_zero, flag_sign, flag_carry, flag_overflow;
  logic [31:0] reg_target;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;

  instr_fetch_unit_if imem ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .imem(imem),
    .opcode(opcode), .function_val(function_val), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm16(imm16), .target26(target26), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .resolve(resolve),
    .counter_selector(counter_selector), .branch_type(branch_type),
    .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_carry(flag_carry),
    .flag_overflow(flag_overflow), .reg_target(reg_target)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [1:0]  sel;
    logic [2:0]  bt;
    logic [3:0]  flags; // {zero, sign, carry, overflow}
    logic [31:0] regt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference next-PC from the architectural rules, using plain integer arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic [1:0] sel, input logic [2:0] bt,
                                           input logic [3:0] fl, input logic [31:0] regt);
    logic [31:0] p4;
    logic [7:0]  tbl;
    int          off;
    p4  = cur + 32'd4;
    tbl = {fl[0], !fl[2], fl[2], !fl[1], fl[1], !fl[3], fl[3], 1'b1};
    off = int'($signed(word[15:0]));
    case (sel)
      2'd0:    return p4;
      2'd1:    return tbl[bt] ? p4 + 32'(off * 4) : p4;
      2'd2:    return (p4 & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
      default: return regt - (regt % 32'd4);
    endcase
  endfunction

  task automatic check_fields(input string tag, input logic [31:0] w);
    chk({tag, " opcode"}, 32'(opcode), 32'(w >> 26));
    chk({tag, " rs"}, 32'(rs), (w >> 21) % 32);
    chk({tag, " rt"}, 32'(rt), (w >> 16) % 32);
    chk({tag, " rd"}, 32'(rd), (w >> 11) % 32);
    chk({tag, " shamt"}, 32'(shamt), (w >> 6) % 32);
    chk({tag, " function_val"}, 32'(function_val), w % 64);
    chk({tag, " imm16"}, 32'(imm16), w % 65536);
    chk({tag, " target26"}, 32'(target26), w % 32'h0400_0000);
  endtask

  // Wait for a request, stall lat cycles, then return word with a one-cycle ack
  task automatic fetch(input string tag, input logic [31:0] word, input int lat, input logic [31:0] exp_addr);
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " req seen"}, 32'(imem.imem_req), 32'd1);
    chk({tag, " addr"}, imem.imem_addr, exp_addr);
    for (int i = 0; i < lat; i++) begin
      imem.imem_ack = 1'b0;
      tick();
      chk({tag, " stall req"}, 32'(imem.imem_req), 32'd1);
      chk({tag, " stall addr"}, imem.imem_addr, exp_addr);
    end
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    tick();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    chk({tag, " valid"}, 32'(instr_valid), 32'd1);
    chk({tag, " req low"}, 32'(imem.imem_req), 32'd0);
    check_fields(tag, word);
  endtask

  task automatic do_resolve(input string tag, input logic [1:0] sel, input logic [2:0] bt,
                            input logic [3:0] fl, input logic [31:0] regt, input logic [31:0] exp_pc);
    resolve = 1'b1; counter_selector = sel; branch_type = bt;
    {flag_zero, flag_sign, flag_carry, flag_overflow} = fl;
    reg_target = regt;
    tick();
    resolve = 1'b0;
    counter_selector = 2'($urandom); branch_type = 3'($urandom);
    {flag_zero, flag_sign, flag_carry, flag_overflow} = 4'($urandom);
    reg_target = $urandom;
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " valid clr"}, 32'(instr_valid), 32'd0);
    chk({tag, " next addr"}, imem.imem_addr, exp_pc);
    chk({tag, " pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    model_pc = exp_pc;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    fetch("goto", $urandom, 0, model_pc);
    do_resolve("goto", 2'd3, 3'd0, 4'd0, target, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_pc = 32'h0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0020, 2'd0, 3'd0, 4'b0000, 32'h0, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'd0, 3'd0, 4'b0000, 32'h0, 32'h0000_0000};
    vecs[2] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd1, 4'b1000, 32'h0, 32'h0000_003C};
    vecs[3] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd1, 4'b0000, 32'h0, 32'h0000_0044};
    vecs[4] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd2, 4'b1000, 32'h0, 32'h0000_0044};
    vecs[5] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd2, 4'b0000, 32'h0, 32'h0000_003C};
    vecs[6] = '{32'h1000_0010, 32'h0800_0040, 2'd2, 3'd0, 4'b0000, 32'h0, 32'h1000_0100};
    vecs[7] = '{32'h1000_0010, 32'h0800_0040, 2'd3, 3'd0, 4'b0000, 32'h0000_2003, 32'h0000_2000};
    vecs[8] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd3, 4'b0010, 32'h0, 32'h0000_003C};
    vecs[9] = '{32'h0000_0040, 32'h1000_FFFE, 2'd1, 3'd7, 4'b1110, 32'h0, 32'h0000_0044};

    reset = 1'b1; resolve = 1'b0; counter_selector = '0; branch_type = '0;
    {flag_zero, flag_sign, flag_carry, flag_overflow} = '0;
    reg_target = '0; imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    tick(); tick();
    chk("reset req", 32'(imem.imem_req), 32'd0);
    chk("reset valid", 32'(instr_valid), 32'd0);
    chk("reset pc", pc, 32'h0);
    chk("reset opcode", 32'(opcode), 32'd0);
    reset = 1'b0;
    chk("idle req before edge", 32'(imem.imem_req), 32'd0);
    tick();
    chk("req after release", 32'(imem.imem_req), 32'd1);
    chk("addr after release", imem.imem_addr, 32'h0);
    model_pc = 32'h0;

    fetch("first", 32'h0000_0020, 2, 32'h0);
    chk("first opcode", 32'(opcode), 32'd0);
    chk("first function_val", 32'(function_val), 32'd32);
    do_resolve("first", 2'd0, 3'd0, 4'd0, 32'h0, 32'h4);

    for (int i = 0; i < 10; i++) begin
      if (model_pc != vecs[i].start_pc) goto_pc(vecs[i].start_pc);
      fetch($sformatf("vec%0d", i), vecs[i].word, 1, vecs[i].start_pc);
      do_resolve($sformatf("vec%0d", i), vecs[i].sel, vecs[i].bt, vecs[i].flags,
                 vecs[i].regt, vecs[i].exp_pc);
    end

    // Reset during FETCH with a simultaneous ack
    goto_pc(32'h0000_0500);
    chk("pre-reset req", 32'(imem.imem_req), 32'd1);
    reset = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem.imem_ack = 1'b0;
    chk("rst-ack valid", 32'(instr_valid), 32'd0);
    chk("rst-ack opcode", 32'(opcode), 32'd0);
    chk("rst-ack imm16", 32'(imm16), 32'd0);
    chk("rst-ack pc", pc, 32'h0);
    chk("rst-ack req", 32'(imem.imem_req), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst-ack fresh req", 32'(imem.imem_req), 32'd1);
    chk("rst-ack fresh addr", imem.imem_addr, 32'h0);
    model_pc = 32'h0;

    // Long stall with a spurious resolve in FETCH, then a spurious ack in ISSUE
    for (int i = 0; i < 5; i++) begin
      resolve = (i == 2); counter_selector = 2'd3; reg_target = 32'h0000_1234;
      tick();
      chk("stall req", 32'(imem.imem_req), 32'd1);
      chk("stall addr", imem.imem_addr, 32'h0);
      chk("stall pc", pc, 32'h0);
    end
    resolve = 1'b0;
    fetch("spur", 32'hABCD_1234, 0, 32'h0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h5555_AAAA;
    tick();
    imem.imem_ack = 1'b0;
    chk("spur ack valid", 32'(instr_valid), 32'd1);
    chk("spur ack req", 32'(imem.imem_req), 32'd0);
    chk("spur ack pc", pc, 32'h0);
    check_fields("spur ack", 32'hABCD_1234);
    do_resolve("spur", 2'd0, 3'd0, 4'd0, 32'h0, 32'h4);

    // Randomized resolves against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w, rt_v, exp;
      logic [1:0]  s;
      logic [2:0]  b;
      logic [3:0]  f;
      w = $urandom; rt_v = $urandom; s = 2'($urandom); b = 3'($urandom); f = 4'($urandom);
      exp = ref_next(model_pc, w, s, b, f, rt_v);
      fetch($sformatf("rnd%0d", i), w, int'($urandom_range(0, 3)), model_pc);
      if ($urandom_range(0, 1) == 1) tick();
      do_resolve($sformatf("rnd%0d", i), s, b, f, rt_v, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
